// File: rtl/mem_bus_pkg.sv
// Shared types for the core memory-bus arbiter.
//   src_e     : identifies which requester issued a bus transaction
//   mem_req_t : the downstream request payload (we, be, addr, wdata)
//   instr_req : builds the payload for an instruction fetch
package mem_bus_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic [3:0] BE_ALL = 4'hF;

    // A fetch is always a full-word read with no write data.
    function automatic mem_req_t instr_req(input logic [31:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.be    = BE_ALL;
        r.addr  = addr;
        r.wdata = 32'h0000_0000;
        return r;
    endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per in-flight bus transaction.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   push, push_src   enqueue the source of a newly granted transaction
//   pop              dequeue the head when its response arrives
//   head_src         source of the oldest outstanding transaction
//   full, empty      occupancy flags
//   count            number of entries held
// Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
module arb_id_fifo
    import mem_bus_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  src_e             push_src,
    input  logic             pop,
    output src_e             head_src,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    src_e             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full      = (cnt_r == CNT_W'(DEPTH));
    assign empty     = (cnt_r == {CNT_W{1'b0}});
    assign count     = cnt_r;
    assign head_src  = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Occupancy update: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_nxt_s = cnt_r;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Tag storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= SRC_INSTR;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_src;
        end
    end

    // Pointers and count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory bus between the instruction-fetch and load/store
// ports. One request is forwarded per cycle; data wins by default, but fetch
// is forced through after STARVE_LIMIT consecutive lost arbitrations. A tag
// FIFO remembers the issuing port of every in-flight transaction so each
// in-order response is routed back to the right requester.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   instr_*                   fetch request / grant / response
//   data_*                    load/store request / grant / response
//   mem_*                     downstream bus request and handshake
//   protocol_err_o            sticky: response arrived with nothing outstanding
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_err_i,
    input  logic [31:0] mem_rdata_i,
    output logic        protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    src_e             head_src_s;
    logic             can_issue_s;
    logic             instr_wins_s;
    logic             mem_req_s;
    logic             grant_s;
    logic             instr_gnt_s;
    logic             data_gnt_s;
    logic             rsp_valid_s;
    mem_req_t         req_s;
    logic [ST_W-1:0]  starve_cnt_r;
    logic [ST_W-1:0]  starve_nxt_s;
    logic             protocol_err_r;

    // Issue decision uses only the registered count: a response frees a slot
    // for the following cycle, never the same one.
    assign can_issue_s  = (cnt_s < CNT_W'(MAX_OUTSTANDING));
    assign instr_wins_s = instr_req_i &
                          (~data_req_i | (starve_cnt_r == ST_W'(STARVE_LIMIT)));
    // rstn is folded in so no request or grant escapes while reset is held.
    assign mem_req_s    = rstn & can_issue_s & (instr_req_i | data_req_i);
    assign grant_s      = mem_req_s & mem_gnt_i;
    assign instr_gnt_s  = grant_s & instr_wins_s;
    assign data_gnt_s   = grant_s & ~instr_wins_s;
    // A response with an empty tag FIFO is stray and is not forwarded.
    assign rsp_valid_s  = rstn & mem_rvalid_i & ~fifo_empty_s;

    // Winner payload onto the downstream bus.
    always_comb begin
        req_s = instr_req(instr_addr_i);
        if (instr_wins_s) begin
            req_s = instr_req(instr_addr_i);
        end else begin
            req_s = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
        end
    end

    assign mem_req_o   = mem_req_s;
    assign mem_we_o    = req_s.we;
    assign mem_be_o    = req_s.be;
    assign mem_addr_o  = req_s.addr;
    assign mem_wdata_o = req_s.wdata;
    assign instr_gnt_o = instr_gnt_s;
    assign data_gnt_o  = data_gnt_s;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (grant_s & ~fifo_full_s),
        .push_src (instr_wins_s ? SRC_INSTR : SRC_DATA),
        .pop      (rsp_valid_s),
        .head_src (head_src_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (cnt_s)
    );

    // Response routing: data and error are broadcast, rvalid is steered.
    assign instr_rvalid_o = rsp_valid_s & (head_src_s == SRC_INSTR);
    assign data_rvalid_o  = rsp_valid_s & (head_src_s == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    // Starvation counter: counts data wins while fetch is also waiting.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (instr_gnt_s) begin
            starve_nxt_s = {ST_W{1'b0}};
        end else if (instr_req_i & data_req_i & data_gnt_s) begin
            if (starve_cnt_r != ST_W'(STARVE_LIMIT)) begin
                starve_nxt_s = starve_cnt_r + ST_W'(1);
            end else begin
                starve_nxt_s = starve_cnt_r;
            end
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_r <= {ST_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    // Sticky flag for responses that have no matching transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            protocol_err_r <= 1'b0;
        end else if (mem_rvalid_i & fifo_empty_s) begin
            protocol_err_r <= 1'b1;
        end else begin
            protocol_err_r <= protocol_err_r;
        end
    end

    assign protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level model (queue of in-flight
// transactions, a loss counter and a sticky error bit) and a simple in-order
// memory responder.
module tb_mem_bus_arbiter;

    localparam int MAX = 2;
    localparam int STV = 4;
    localparam logic [31:0] KEY = 32'h5A5A_3C3C;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic [3:0]  dbe;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;
    logic        protocol_err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(STV)) dut (
        .clk(clk), .rstn(rstn),
        .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
        .data_wdata_i(dwdata), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
        .mem_rdata_i(mem_rdata), .protocol_err_o(protocol_err_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;
    bit err_en = 1'b0;

    // Reference model: in-flight transactions in issue order.
    typedef struct { bit src; logic [31:0] d; logic e; } ent_t;
    typedef struct { int due; logic [31:0] d; logic e; } rsp_t;
    ent_t q[$];
    rsp_t mq[$];
    int   st   = 0;
    bit   perr = 1'b0;

    bit          e_can, e_mr, e_iw, e_ig, e_dg, e_irv, e_drv, e_we, e_err;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_rdata;

    function automatic void predict();
        e_can   = (q.size() < MAX);
        e_mr    = rstn && e_can && (ireq || dreq);
        e_iw    = ireq && (!dreq || st == STV);
        e_ig    = e_mr && mem_gnt && e_iw;
        e_dg    = e_mr && mem_gnt && !e_iw;
        e_addr  = e_iw ? iaddr : daddr;
        e_we    = e_iw ? 1'b0 : dwe;
        e_be    = e_iw ? 4'hF : dbe;
        e_wdata = e_iw ? 32'h0 : dwdata;
        e_irv   = 1'b0;
        e_drv   = 1'b0;
        e_rdata = 32'h0;
        e_err   = 1'b0;
        if (rstn && mem_rvalid && q.size() > 0) begin
            e_irv   = (q[0].src == 1'b0);
            e_drv   = (q[0].src == 1'b1);
            e_rdata = q[0].d;
            e_err   = q[0].e;
        end
    endfunction

    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mq[0].d;
            mem_err    = mq[0].e;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_err    = 1'b0;
        end
    endtask

    // Advance one clock: update model and memory from the predicted decision.
    task automatic tick();
        logic [31:0] d;
        logic        e;
        predict();
        @(posedge clk);
        if (mem_rvalid) void'(mq.pop_front());
        if (!rstn) begin
            q.delete();
            st   = 0;
            perr = 1'b0;
        end else begin
            if (mem_rvalid) begin
                if (q.size() == 0) perr = 1'b1;
                else void'(q.pop_front());
            end
            if (e_ig || e_dg) begin
                d = e_addr ^ KEY;
                e = err_en ? ($urandom_range(0, 7) == 0) : 1'b0;
                q.push_back('{e_dg, d, e});
                mq.push_back('{cyc + lat, d, e});
            end
            if (ireq && dreq && e_can && e_dg) begin
                if (st < STV) st++;
            end else if (e_ig) begin
                st = 0;
            end
        end
        cyc++;
        @(negedge clk);
        mem_drive();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ireq = 1'b0; dreq = 1'b0; mem_gnt = 1'b0;
        mq.delete(); q.delete(); st = 0; perr = 1'b0;
        mem_drive();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ireq = 1'b1; iaddr = 32'h40; dreq = 1'b1; daddr = 32'h80;
        dwe = 1'b1; dbe = 4'h3; dwdata = 32'h1234_5678;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_err = 1'b0; mem_rdata = 32'h0;
        #2;
        tests++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o});
        end
        @(negedge clk); #1;
        tests++;
        if (protocol_err_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_perr_held got=%b exp=0", protocol_err_o);
        end
        do_reset();
    endtask

    task automatic test_instr_only();
        do_reset();
        lat = 1; mem_gnt = 1'b1; dreq = 1'b0;
        for (int k = 0; k < 5; k++) begin
            ireq  = (k < 3);
            iaddr = 32'(4 * k);
            #1;
            tests++;
            if (instr_gnt_o !== (k < 3)) begin
                fails++; $display("FAIL instr_only_gnt k=%0d got=%b exp=%b", k, instr_gnt_o, (k < 3));
            end
            tests++;
            if (instr_rvalid_o !== (k >= 1 && k <= 3)) begin
                fails++; $display("FAIL instr_only_rvalid k=%0d got=%b exp=%b", k, instr_rvalid_o, (k >= 1 && k <= 3));
            end else if (k >= 1 && k <= 3) begin
                tests++;
                if (instr_rdata_o !== (32'(4 * (k - 1)) ^ KEY)) begin
                    fails++; $display("FAIL instr_only_rdata k=%0d got=%h exp=%h", k, instr_rdata_o, 32'(4 * (k - 1)) ^ KEY);
                end
            end
            tests++;
            if ({data_gnt_o, data_rvalid_o} !== 2'b00) begin
                fails++; $display("FAIL instr_only_data_silent k=%0d got=%b exp=00", k, {data_gnt_o, data_rvalid_o});
            end
            if (k < 3) begin
                tests++;
                if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {1'b0, 4'hF, 32'(4 * k), 32'h0}) begin
                    fails++; $display("FAIL instr_only_bus k=%0d got we=%b be=%h a=%h wd=%h", k, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_starvation();
        do_reset();
        lat = 1; mem_gnt = 1'b1; ireq = 1'b1; dreq = 1'b1;
        iaddr = 32'h1000; daddr = 32'h2000; dwe = 1'b0; dbe = 4'hF;
        for (int k = 0; k < 15; k++) begin
            #1;
            tests++;
            if ({instr_gnt_o, data_gnt_o} !== {(k % 5 == 4), (k % 5 != 4)}) begin
                fails++; $display("FAIL starve_pattern k=%0d got=%b exp=%b", k, {instr_gnt_o, data_gnt_o}, {(k % 5 == 4), (k % 5 != 4)});
            end
            tick();
        end
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        lat = 3; mem_gnt = 1'b1; ireq = 1'b1; dreq = 1'b1;
        for (int k = 0; k < 12; k++) begin
            iaddr = 32'(16 * k); daddr = 32'(16 * k + 8);
            #1;
            predict();
            tests++;
            if (mem_req_o !== (k % 4 < 2)) begin
                fails++; $display("FAIL limit_req k=%0d got=%b exp=%b", k, mem_req_o, (k % 4 < 2));
            end
            tests++;
            if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o} !== {e_ig, e_dg, e_irv, e_drv}) begin
                fails++; $display("FAIL limit_route k=%0d got=%b exp=%b", k,
                                  {instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o}, {e_ig, e_dg, e_irv, e_drv});
            end
            tick();
        end
    endtask

    task automatic test_grant_and_response();
        do_reset();
        lat = 1; mem_gnt = 1'b1;
        ireq = 1'b0; dreq = 1'b1; daddr = 32'h100; dwe = 1'b0; dbe = 4'hF;
        #1; tests++;
        if (data_gnt_o !== 1'b1) begin fails++; $display("FAIL same_cycle_c0 got=%b exp=1", data_gnt_o); end
        tick();
        dreq = 1'b0; ireq = 1'b1; iaddr = 32'h200;
        #1; tests++;
        if ({instr_gnt_o, data_rvalid_o, data_rdata_o} !== {1'b1, 1'b1, 32'h100 ^ KEY}) begin
            fails++; $display("FAIL same_cycle_c1 got=%b%b %h exp=11 %h", instr_gnt_o, data_rvalid_o, data_rdata_o, 32'h100 ^ KEY);
        end
        tick();
        ireq = 1'b0; dreq = 1'b1; daddr = 32'h300;
        #1; tests++;
        if ({instr_rvalid_o, data_rvalid_o, data_gnt_o, instr_rdata_o} !== {3'b101, 32'h200 ^ KEY}) begin
            fails++; $display("FAIL same_cycle_c2 got=%b%b%b %h exp=101 %h", instr_rvalid_o, data_rvalid_o, data_gnt_o, instr_rdata_o, 32'h200 ^ KEY);
        end
        tick();
        dreq = 1'b0;
        #1; tests++;
        if ({instr_rvalid_o, data_rvalid_o, data_rdata_o, protocol_err_o} !== {2'b01, 32'h300 ^ KEY, 1'b0}) begin
            fails++; $display("FAIL same_cycle_c3 got=%b%b %h %b exp=01 %h 0", instr_rvalid_o, data_rvalid_o, data_rdata_o, protocol_err_o, 32'h300 ^ KEY);
        end
        tick();
    endtask

    task automatic test_stray_response();
        do_reset();
        mq.push_back('{cyc, 32'hDEAD_BEEF, 1'b0});
        mem_drive();
        #1; tests++;
        if ({instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 3'b000) begin
            fails++; $display("FAIL stray_drop got=%b exp=000", {instr_rvalid_o, data_rvalid_o, protocol_err_o});
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            #1; tests++;
            if (protocol_err_o !== 1'b1) begin
                fails++; $display("FAIL stray_sticky k=%0d got=%b exp=1", k, protocol_err_o);
            end
            tick();
        end
        rstn = 1'b0;
        #2; tests++;
        if (protocol_err_o !== 1'b0) begin
            fails++; $display("FAIL stray_reset_clear got=%b exp=0", protocol_err_o);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        lat = 6; mem_gnt = 1'b1; ireq = 1'b1; dreq = 1'b1;
        iaddr = 32'h500; daddr = 32'h600;
        tick(); tick();
        ireq = 1'b1; dreq = 1'b0;
        #1; tests++;
        if (mem_req_o !== 1'b0) begin
            fails++; $display("FAIL midflight_full got=%b exp=0", mem_req_o);
        end
        #2 rstn = 1'b0;
        #1; tests++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
            fails++; $display("FAIL midflight_reset_outputs got=%b exp=000000",
                              {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o});
        end
        ireq = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1; predict(); tests++;
            if ({instr_rvalid_o, data_rvalid_o, protocol_err_o} !== {e_irv, e_drv, perr}) begin
                fails++; $display("FAIL midflight_late k=%0d got=%b exp=%b", k, {instr_rvalid_o, data_rvalid_o, protocol_err_o}, {e_irv, e_drv, perr});
            end
            tick();
        end
        ireq = 1'b1;
        #1; tests++;
        if ({instr_gnt_o, protocol_err_o} !== 2'b11) begin
            fails++; $display("FAIL midflight_after got=%b exp=11", {instr_gnt_o, protocol_err_o});
        end
        tick();
        ireq = 1'b0;
    endtask

    task automatic test_random_traffic();
        do_reset();
        err_en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            lat = c;
            for (int k = 0; k < 200; k++) begin
                if (!ireq) begin
                    ireq  = 1'($urandom_range(0, 1));
                    iaddr = $urandom & 32'hFFFF_FFFC;
                end
                if (!dreq) begin
                    dreq   = 1'($urandom_range(0, 1));
                    daddr  = $urandom;
                    dwe    = 1'($urandom_range(0, 1));
                    dbe    = 4'($urandom_range(0, 15));
                    dwdata = $urandom;
                end
                mem_gnt = ($urandom_range(0, 3) != 0);
                #1; predict(); tests++;
                if ({mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !==
                    {e_mr, e_ig, e_dg, e_irv, e_drv, perr}) begin
                    fails++; $display("FAIL rand_ctrl cyc=%0d got=%b exp=%b", cyc,
                        {mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o},
                        {e_mr, e_ig, e_dg, e_irv, e_drv, perr});
                end
                if (e_mr) begin
                    tests++;
                    if ({mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {e_we, e_be, e_addr, e_wdata}) begin
                        fails++; $display("FAIL rand_bus cyc=%0d got=%b %h %h %h exp=%b %h %h %h", cyc,
                            mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, e_we, e_be, e_addr, e_wdata);
                    end
                end
                if (e_irv) begin
                    tests++;
                    if ({instr_rdata_o, instr_err_o} !== {e_rdata, e_err}) begin
                        fails++; $display("FAIL rand_irsp cyc=%0d got=%h %b exp=%h %b", cyc, instr_rdata_o, instr_err_o, e_rdata, e_err);
                    end
                end
                if (e_drv) begin
                    tests++;
                    if ({data_rdata_o, data_err_o} !== {e_rdata, e_err}) begin
                        fails++; $display("FAIL rand_drsp cyc=%0d got=%h %b exp=%h %b", cyc, data_rdata_o, data_err_o, e_rdata, e_err);
                    end
                end
                tick();
                if (e_ig) ireq = 1'b0;
                if (e_dg) dreq = 1'b0;
            end
            ireq = 1'b0; dreq = 1'b0;
            for (int w = 0; w < 20 && mq.size() > 0; w++) tick();
        end
        err_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_instr_only();
        test_starvation();
        test_outstanding_limit();
        test_grant_and_response();
        test_stray_response();
        test_reset_mid_flight();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
